// File: rtl/edge_gen_pkg.sv
// Shared types and helpers for the multi-lane edge generator.
// Lane state is kept as one packed struct so a lane is a single register bank.
package edge_gen_pkg;

    localparam int HOLD_W_MAX = 16;

    function automatic int hold_cnt_w(input int min_hold);
        return (min_hold > 2) ? $clog2(min_hold) : 1;
    endfunction

    typedef struct packed {
        logic                  level;
        logic [HOLD_W_MAX-1:0] hold_cnt;
        logic                  pend;
    } lane_state_t;

endpackage

// File: rtl/edge_gen_lane.sv
// One lane: registered level with a minimum hold window, deferral of edges
// requested during the window, and glitch cancellation of deferred edges.
module edge_gen_lane
    import edge_gen_pkg::*;
#(
    parameter int   MIN_HOLD    = 4,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic CLK,
    input  logic nRST,
    input  logic rise_req,
    input  logic fall_req,
    output logic signal_out,
    output logic busy,
    output logic cancel,
    output logic conflict
);

    localparam int                    HW       = hold_cnt_w(MIN_HOLD);
    localparam logic [HW-1:0]         LOAD     = HW'(MIN_HOLD - 1);
    // Counter only ever holds HW-bit values; the upper struct bits stay zero.
    localparam logic [HOLD_W_MAX-1:0] LOAD_EXT = HOLD_W_MAX'(LOAD);
    localparam logic [HOLD_W_MAX-1:0] ONE      = HOLD_W_MAX'(1);

    lane_state_t st;
    logic        cnt_zero;
    logic        opp_req;
    logic        same_req;

    assign cnt_zero = (st.hold_cnt == '0);
    assign opp_req  = (rise_req & ~st.level) | (fall_req & st.level);
    assign same_req = (rise_req & st.level) | (fall_req & ~st.level);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            st.level    <= RESET_LEVEL;
            st.hold_cnt <= '0;
            st.pend     <= 1'b0;
            cancel      <= 1'b0;
            conflict    <= 1'b0;
        end else begin
            cancel   <= 1'b0;
            conflict <= 1'b0;
            if (rise_req && fall_req) begin
                // Level and pending edge are frozen; the hold window is time based and keeps running.
                conflict <= 1'b1;
                if (!cnt_zero) st.hold_cnt <= st.hold_cnt - ONE;
            end else if (cnt_zero && (st.pend || opp_req)) begin
                st.level    <= ~st.level;
                st.hold_cnt <= LOAD_EXT;
                st.pend     <= 1'b0;
            end else if (!cnt_zero) begin
                st.hold_cnt <= st.hold_cnt - ONE;
                if (opp_req && !st.pend) begin
                    st.pend <= 1'b1;
                end else if (st.pend && same_req) begin
                    st.pend <= 1'b0;
                    cancel  <= 1'b1;
                end
            end
        end
    end

    assign signal_out = st.level;
    assign busy       = ~cnt_zero | st.pend;

endmodule

// File: rtl/edge_generator.sv
// Multi-lane rate-limited level generator; lanes are independent copies.
module edge_generator
    import edge_gen_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter int               MIN_HOLD    = 4,
    parameter logic [WIDTH-1:0] RESET_LEVEL = '0
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [WIDTH-1:0] rise_req,
    input  logic [WIDTH-1:0] fall_req,
    output logic [WIDTH-1:0] signal_out,
    output logic [WIDTH-1:0] busy,
    output logic [WIDTH-1:0] cancel,
    output logic [WIDTH-1:0] conflict
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        edge_gen_lane #(
            .MIN_HOLD    (MIN_HOLD),
            .RESET_LEVEL (RESET_LEVEL[i])
        ) u_lane (
            .CLK        (CLK),
            .nRST       (nRST),
            .rise_req   (rise_req[i]),
            .fall_req   (fall_req[i]),
            .signal_out (signal_out[i]),
            .busy       (busy[i]),
            .cancel     (cancel[i]),
            .conflict   (conflict[i])
        );
    end

endmodule

// File: tb/tb_edge_generator.sv
// Bench for edge_generator: directed table, randomized run against a timing model,
// mid-hold reset with RESET_LEVEL=1, and a MIN_HOLD=1 loopback into an edge detector.
module tb_edge_generator;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       rst_a, rst_b, rst_c;
    logic [1:0] rise_a, fall_a, out_a, busy_a, cancel_a, conflict_a;
    logic [0:0] rise_b, fall_b, out_b, busy_b, cancel_b, conflict_b;
    logic [1:0] rise_c, fall_c, out_c, busy_c, cancel_c, conflict_c;

    edge_generator #(.WIDTH(2), .MIN_HOLD(4), .RESET_LEVEL(2'b00)) dut_a (
        .CLK(CLK), .nRST(rst_a), .rise_req(rise_a), .fall_req(fall_a),
        .signal_out(out_a), .busy(busy_a), .cancel(cancel_a), .conflict(conflict_a));

    edge_generator #(.WIDTH(1), .MIN_HOLD(4), .RESET_LEVEL(1'b1)) dut_b (
        .CLK(CLK), .nRST(rst_b), .rise_req(rise_b), .fall_req(fall_b),
        .signal_out(out_b), .busy(busy_b), .cancel(cancel_b), .conflict(conflict_b));

    edge_generator #(.WIDTH(2), .MIN_HOLD(1), .RESET_LEVEL(2'b00)) dut_c (
        .CLK(CLK), .nRST(rst_c), .rise_req(rise_c), .fall_req(fall_c),
        .signal_out(out_c), .busy(busy_c), .cancel(cancel_c), .conflict(conflict_c));

    int errs   = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference model: a lane is free once MIN_HOLD edges have passed since its last applied edge.
    typedef struct {
        int lvl;
        int last;
        bit pend;
    } mlane_t;

    function automatic void mstep(inout mlane_t s, input int n, input int h, input bit r, input bit f,
                                  output bit c, output bit x, output int dir);
        bit free_l, opp, same;
        c = 0; x = 0; dir = 0;
        free_l = (n - s.last) >= h;
        opp    = (r && s.lvl == 0) || (f && s.lvl == 1);
        same   = (r && s.lvl == 1) || (f && s.lvl == 0);
        if (r && f) begin
            x = 1;
        end else if (free_l && (s.pend || opp)) begin
            s.lvl  = 1 - s.lvl;
            s.last = n;
            s.pend = 0;
            dir    = (s.lvl == 1) ? 1 : -1;
        end else if (!free_l) begin
            if (opp && !s.pend) s.pend = 1;
            else if (s.pend && same) begin
                s.pend = 0;
                c      = 1;
            end
        end
    endfunction

    function automatic bit mbusy(input mlane_t s, input int n, input int h);
        return ((n + 1 - s.last) < h) || s.pend;
    endfunction

    typedef struct {
        bit r; bit f; bit o; bit b; bit c; bit x;
    } vec_t;
    vec_t tbl[29];

    mlane_t ml[2];

    initial begin
        bit   c_e, x_e;
        int   dir;
        logic [1:0] prev_c, pos, neg;

        tbl[0]  = '{1,0, 1,1,0,0};  tbl[1]  = '{0,1, 1,1,0,0};
        tbl[2]  = '{0,0, 1,1,0,0};  tbl[3]  = '{0,0, 1,1,0,0};
        tbl[4]  = '{0,0, 0,1,0,0};  tbl[5]  = '{0,0, 0,1,0,0};
        tbl[6]  = '{0,0, 0,1,0,0};  tbl[7]  = '{0,0, 0,0,0,0};
        tbl[8]  = '{1,0, 1,1,0,0};  tbl[9]  = '{0,1, 1,1,0,0};
        tbl[10] = '{1,0, 1,1,1,0};  tbl[11] = '{0,0, 1,0,0,0};
        tbl[12] = '{0,0, 1,0,0,0};  tbl[13] = '{1,1, 1,0,0,1};
        tbl[14] = '{0,0, 1,0,0,0};  tbl[15] = '{1,0, 1,0,0,0};
        tbl[16] = '{0,1, 0,1,0,0};  tbl[17] = '{0,1, 0,1,0,0};
        tbl[18] = '{1,0, 0,1,0,0};  tbl[19] = '{1,0, 0,1,0,0};
        tbl[20] = '{0,0, 1,1,0,0};  tbl[21] = '{0,1, 1,1,0,0};
        tbl[22] = '{0,0, 1,1,0,0};  tbl[23] = '{0,0, 1,1,0,0};
        tbl[24] = '{0,0, 0,1,0,0};  tbl[25] = '{0,0, 0,1,0,0};
        tbl[26] = '{0,0, 0,1,0,0};  tbl[27] = '{0,0, 0,0,0,0};
        tbl[28] = '{1,0, 1,1,0,0};

        rst_a = 0; rst_b = 0; rst_c = 0;
        rise_a = 0; fall_a = 0; rise_b = 0; fall_b = 0; rise_c = 0; fall_c = 0;
        #12;
        check("rst_out_a", out_a, 0);
        check("rst_busy_a", busy_a, 0);
        check("rst_cancel_a", cancel_a, 0);
        check("rst_conflict_a", conflict_a, 0);
        check("rst_out_b", out_b, 1);
        check("rst_busy_b", busy_b, 0);
        rst_a = 1; rst_b = 1; rst_c = 1;
        @(posedge CLK); #1;

        // Directed sequence on lane 0 of dut_a; lane 1 stays idle.
        for (int i = 0; i < 29; i++) begin
            rise_a = {1'b0, tbl[i].r};
            fall_a = {1'b0, tbl[i].f};
            @(posedge CLK); #1;
            check($sformatf("tbl%0d_out", i), out_a[0], tbl[i].o);
            check($sformatf("tbl%0d_busy", i), busy_a[0], tbl[i].b);
            check($sformatf("tbl%0d_cancel", i), cancel_a[0], tbl[i].c);
            check($sformatf("tbl%0d_conflict", i), conflict_a[0], tbl[i].x);
            check($sformatf("tbl%0d_lane1", i), {out_a[1], busy_a[1], cancel_a[1], conflict_a[1]}, 0);
        end
        rise_a = 0; fall_a = 0;

        // Randomized run on dut_a after a fresh reset.
        #2 rst_a = 0;
        #1 check("rnd_rst_out", out_a, 0);
        check("rnd_rst_busy", busy_a, 0);
        #2 rst_a = 1;
        for (int l = 0; l < 2; l++) ml[l] = '{0, -1000, 0};
        for (int n = 0; n < 400; n++) begin
            logic [1:0] r, f;
            for (int l = 0; l < 2; l++) begin
                int k;
                k = $urandom_range(0, 9);
                r[l] = (k < 3) || (k == 9);
                f[l] = (k >= 3 && k < 6) || (k == 9);
            end
            rise_a = r; fall_a = f;
            @(posedge CLK); #1;
            for (int l = 0; l < 2; l++) begin
                mstep(ml[l], n, 4, r[l], f[l], c_e, x_e, dir);
                check($sformatf("rnd%0d_l%0d_out", n, l), out_a[l], ml[l].lvl);
                check($sformatf("rnd%0d_l%0d_busy", n, l), busy_a[l], mbusy(ml[l], n, 4));
                check($sformatf("rnd%0d_l%0d_cancel", n, l), cancel_a[l], c_e);
                check($sformatf("rnd%0d_l%0d_conflict", n, l), conflict_a[l], x_e);
            end
        end
        rise_a = 0; fall_a = 0;

        // Reset mid-pending with RESET_LEVEL=1.
        fall_b = 1;
        @(posedge CLK); #1;
        check("rstb_fall_out", out_b, 0);
        check("rstb_fall_busy", busy_b, 1);
        fall_b = 0; rise_b = 1;
        @(posedge CLK); #1;
        check("rstb_pend_out", out_b, 0);
        check("rstb_pend_busy", busy_b, 1);
        rise_b = 0;
        @(posedge CLK); #2;
        rst_b = 0;
        #1;
        check("rstb_async_out", out_b, 1);
        check("rstb_async_busy", busy_b, 0);
        check("rstb_async_cancel", cancel_b, 0);
        #2 rst_b = 1;
        for (int n = 0; n < 6; n++) begin
            @(posedge CLK); #1;
            check($sformatf("rstb_idle%0d_out", n), out_b, 1);
            check($sformatf("rstb_idle%0d_busy", n), busy_b, 0);
        end
        fall_b = 1;
        @(posedge CLK); #1;
        check("rstb_first_req_out", out_b, 0);
        fall_b = 0;

        // Loopback with MIN_HOLD=1 into an edge detector.
        for (int l = 0; l < 2; l++) ml[l] = '{0, -1000, 0};
        prev_c = out_c;
        for (int n = 0; n < 300; n++) begin
            logic [1:0] r, f;
            int d[2];
            bit xe[2];
            for (int l = 0; l < 2; l++) begin
                int k;
                k = $urandom_range(0, 9);
                r[l] = (k < 4) || (k == 9);
                f[l] = (k >= 4 && k < 8) || (k == 9);
            end
            rise_c = r; fall_c = f;
            @(posedge CLK); #1;
            pos = out_c & ~prev_c;
            neg = ~out_c & prev_c;
            prev_c = out_c;
            for (int l = 0; l < 2; l++) begin
                mstep(ml[l], n, 1, r[l], f[l], c_e, x_e, dir);
                d[l] = dir;
                xe[l] = x_e;
            end
            for (int l = 0; l < 2; l++) begin
                check($sformatf("lb%0d_l%0d_pos", n, l), pos[l], d[l] == 1);
                check($sformatf("lb%0d_l%0d_neg", n, l), neg[l], d[l] == -1);
                check($sformatf("lb%0d_l%0d_busy", n, l), busy_c[l], 0);
                check($sformatf("lb%0d_l%0d_conflict", n, l), conflict_c[l], xe[l]);
            end
        end
        rise_c = 0; fall_c = 0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/edge_generator.md
# edge_generator

Multi-lane level-signal generator, the transmit-side counterpart of the edge detector. Each lane accepts single-cycle rise/fall request strobes and drives a registered level output. Every level lasts at least `MIN_HOLD` cycles, and requests that arrive during a hold window are deferred. An opposite request during that window cancels the deferred one, which suppresses glitches. The block sits wherever the design must produce clean, rate-limited level signals for downstream edge-detecting logic.

## Interface
Parameters:
- `WIDTH`, default 1: number of independent lanes.
- `MIN_HOLD`, default 4: minimum cycles a level is held after an edge. Must be ≥ 1; 1 means no hold-off.
- `RESET_LEVEL`, default `'0` (`WIDTH` bits): per-lane output level after reset.

Ports:
- `CLK`, input, 1: clock. All state updates on the rising edge.
- `nRST`, input, 1: reset, asynchronous, active-low.
- `rise_req`, input, `WIDTH`: per-lane single-cycle request to drive the level high.
- `fall_req`, input, `WIDTH`: per-lane single-cycle request to drive the level low.
- `signal_out`, output, `WIDTH`: registered level output.
- `busy`, output, `WIDTH`: lane is in a hold window or has a deferred edge.
- `cancel`, output, `WIDTH`: registered one-cycle pulse when a deferred edge is cancelled.
- `conflict`, output, `WIDTH`: registered one-cycle pulse when `rise_req` and `fall_req` are asserted together.

## Operation
Per-lane state:
- `level`: drives `signal_out`.
- `hold_cnt`: width `$clog2(MIN_HOLD)`, minimum 1 bit.
- `pend`: 1 bit, deferred edge flag.
- Reset values: `level` = `RESET_LEVEL[i]`, `hold_cnt` = 0, `pend` = 0, `cancel` = 0, `conflict` = 0.

Request classification, from pre-edge state:
- Opposite request: `rise_req` while `level` = 0, or `fall_req` while `level` = 1.
- Same request: a request matching the current `level`.

Per-cycle priority, evaluated each rising edge:
1. Both `rise_req` and `fall_req` high: no state change except `conflict` = 1.
2. `hold_cnt` == 0 and (`pend` or an opposite request):
   - `level` toggles.
   - `hold_cnt` loads `MIN_HOLD`-1.
   - `pend` clears.
3. `hold_cnt` != 0 and an opposite request with `pend` = 0: `pend` sets.
4. `hold_cnt` != 0, `pend` = 1 and a same request: `pend` clears and `cancel` = 1. The request returns the lane to its current level, so the deferred edge is dropped.
5. All other requests are ignored. This covers a same request with `pend` = 0, and a repeat of the pending direction.
6. `hold_cnt` decrements when nonzero and no edge is applied this cycle.

Outputs:
- `busy` = (`hold_cnt` != 0) | `pend`. Combinational from registers.
- With `MIN_HOLD` = 1, `hold_cnt` is always 0, `pend` never sets, and every opposite request applies immediately.
- `cancel` and `conflict` are low in every cycle where their condition is absent.
- Lanes are fully independent; there is no cross-lane interaction.

## Timing
- Request to output latency is one edge. A request sampled high at edge k with the lane free changes `signal_out` immediately after edge k.
- An edge applied at edge k holds the new level for edges k+1 through k+`MIN_HOLD`-1. The earliest next edge is k+`MIN_HOLD`.
- A deferred edge applies at the first edge where `hold_cnt` == 0. That is exactly edge k+`MIN_HOLD` if it is still pending.
- A request arriving at the exact edge where `hold_cnt` == 0 applies directly and is never deferred.
- Asserting `nRST` mid-hold or mid-pending immediately forces the reset values listed under Operation. The first request after deassertion is treated as on a free lane.
- Feeding `signal_out` into the edge detector produces one pos or neg pulse per applied edge. Cancelled and conflicting requests produce none.

## Structure
- Shared package `edge_gen_pkg` holds:
  - the hold counter width function;
  - a `lane_state_t` struct with `level`, `hold_cnt` and `pend`.
- Sub-module `edge_gen_lane` implements one lane with scalar ports. The top instantiates `WIDTH` copies in a generate loop and passes `RESET_LEVEL[i]`.

## Test plan
All scenarios use `MIN_HOLD` = 4 and `RESET_LEVEL` = 0 unless stated.
- Reset check: assert `nRST` → `signal_out` = 0, `busy` = 0, `cancel` = 0, `conflict` = 0.
- Immediate edge plus deferral:
  - `rise_req` at edge 0 → `signal_out` = 1 after edge 0.
  - `fall_req` at edge 1 → `busy` = 1; `signal_out` stays 1 through edge 3 and goes to 0 after edge 4.
- Glitch cancel:
  - `rise_req` at edge 10 → `signal_out` = 1.
  - `fall_req` at edge 11 → deferred.
  - `rise_req` at edge 12 → `cancel` pulses after edge 12.
  - `signal_out` stays 1; `busy` drops after edge 13.
- Conflict and redundancy:
  - `rise_req` and `fall_req` together on a free lane → `conflict` pulses for 1 cycle, `signal_out` unchanged.
  - `rise_req` while `signal_out` = 1 and the lane is free → no change.
- Reset mid-operation, with `RESET_LEVEL` = 1:
  - `fall_req` at edge 0 → `signal_out` = 0.
  - `rise_req` at edge 1 → `pend` sets.
  - Pulse `nRST` low between edges 2 and 3 → `signal_out` = 1 and `busy` = 0 immediately, with no later edge.
- Loopback with `WIDTH` = 2 and `MIN_HOLD` = 1:
  - Drive random requests and feed `signal_out` into the edge detector.
  - Every applied edge yields exactly one matching pos/neg pulse on that lane only.
